// File: rtl/cl_axi_bar1_regs.sv
// rtl/cl_axi_bar1_regs.sv - AXI-4 slave bank of 64-bit control/status registers for BAR1
module cl_axi_bar1_regs #(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [63:0] VERSION  = 64'h0000_0001_0000_0000
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,

    input  logic [3:0]  s_axi_awid,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,

    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,

    output logic [3:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,

    input  logic [3:0]  s_axi_arid,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,

    output logic [3:0]  s_axi_rid,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Word address carries one spare bit so an INCR burst running off the top of the
    // 32-bit space keeps decoding as out of span instead of wrapping to register 0.
    function automatic logic [1:0] beat_err(input logic [29:0] word, input logic cfg_err,
                                            input logic is_write);
        if ((word >> IDX_W) != 30'd0)
            return RESP_DECERR;
        else if (cfg_err || (is_write && word == 30'd0))
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

    logic        rdy_en;
    logic [63:0] regs [NUM_REGS];

    logic [1:0]  w_state;
    logic [3:0]  w_id;
    logic [29:0] w_word;
    logic [7:0]  w_len;
    logic [7:0]  w_beat;
    logic [1:0]  w_burst;
    logic        w_cfg_err;
    logic [1:0]  w_err;
    logic [1:0]  w_beat_err;
    logic        w_fire;

    logic [0:0]  r_state;
    logic [3:0]  r_id;
    logic [29:0] r_word;
    logic [7:0]  r_len;
    logic [7:0]  r_beat;
    logic [1:0]  r_burst;
    logic        r_cfg_err;
    logic [63:0] r_data;
    logic [1:0]  r_resp;

    logic [29:0] r_next_word;
    logic        r_next_cfg;
    logic [1:0]  r_next_err;
    logic [63:0] r_next_data;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_awaddr[2:0], s_axi_araddr[2:0]};

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n)
            rdy_en <= 1'b0;
        else
            rdy_en <= 1'b1;
    end

    assign s_axi_awready = rdy_en && (w_state == W_IDLE);
    assign s_axi_wready  = (w_state == W_DATA);
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_bid     = w_id;
    assign s_axi_bresp   = w_err;

    assign w_fire     = (w_state == W_DATA) && s_axi_wvalid;
    assign w_beat_err = beat_err(w_word, w_cfg_err, 1'b1);

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            w_state   <= W_IDLE;
            w_id      <= 4'd0;
            w_word    <= 30'd0;
            w_len     <= 8'd0;
            w_beat    <= 8'd0;
            w_burst   <= 2'b00;
            w_cfg_err <= 1'b0;
            w_err     <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_state   <= W_DATA;
                        w_id      <= s_axi_awid;
                        w_word    <= {1'b0, s_axi_awaddr[31:3]};
                        w_len     <= s_axi_awlen;
                        w_beat    <= 8'd0;
                        w_burst   <= s_axi_awburst;
                        w_cfg_err <= (s_axi_awsize > 3'd3) || s_axi_awburst[1];
                        w_err     <= RESP_OKAY;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        if (w_beat_err > w_err)
                            w_err <= w_beat_err;
                        // An early wlast is legal and simply closes the burst.
                        if (s_axi_wlast || w_beat == w_len) begin
                            w_state <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                            if (w_burst == BURST_INCR)
                                w_word <= w_word + 30'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready)
                        w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++)
                regs[i] <= 64'd0;
        end else if (w_fire && w_beat_err == RESP_OKAY) begin
            for (int b = 0; b < 8; b++)
                if (s_axi_wstrb[b])
                    regs[w_word[IDX_W-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
    end

    // The next read beat is decoded from the current register contents, so a write
    // landing on the same edge is seen only by beats loaded afterwards.
    always_comb begin
        r_next_word = r_word;
        r_next_cfg  = r_cfg_err;
        if (r_state == R_IDLE) begin
            r_next_word = {1'b0, s_axi_araddr[31:3]};
            r_next_cfg  = (s_axi_arsize > 3'd3) || s_axi_arburst[1];
        end else if (r_burst == BURST_INCR) begin
            r_next_word = r_word + 30'd1;
        end
        r_next_err  = beat_err(r_next_word, r_next_cfg, 1'b0);
        r_next_data = 64'd0;
        if (r_next_err == RESP_OKAY)
            r_next_data = (r_next_word == 30'd0) ? VERSION : regs[r_next_word[IDX_W-1:0]];
    end

    assign s_axi_arready = rdy_en && (r_state == R_IDLE);
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_rlast   = (r_state == R_DATA) && (r_beat == r_len);
    assign s_axi_rid     = r_id;
    assign s_axi_rdata   = r_data;
    assign s_axi_rresp   = r_resp;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_state   <= R_IDLE;
            r_id      <= 4'd0;
            r_word    <= 30'd0;
            r_len     <= 8'd0;
            r_beat    <= 8'd0;
            r_burst   <= 2'b00;
            r_cfg_err <= 1'b0;
            r_data    <= 64'd0;
            r_resp    <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_state   <= R_DATA;
                        r_id      <= s_axi_arid;
                        r_word    <= r_next_word;
                        r_len     <= s_axi_arlen;
                        r_beat    <= 8'd0;
                        r_burst   <= s_axi_arburst;
                        r_cfg_err <= r_next_cfg;
                        r_data    <= r_next_data;
                        r_resp    <= r_next_err;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (r_beat == r_len) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_word <= r_next_word;
                            r_data <= r_next_data;
                            r_resp <= r_next_err;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cl_axi_bar1_regs.sv
// tb/tb_cl_axi_bar1_regs.sv - directed and randomized checks of cl_axi_bar1_regs against a register-array model
module tb_cl_axi_bar1_regs;

    localparam int unsigned NUM = 16;
    localparam logic [63:0] VER = 64'h0000_0001_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int total = 0;
    int bad = 0;

    logic [63:0] mregs [NUM];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    cl_axi_bar1_regs #(.NUM_REGS(NUM), .VERSION(VER)) dut (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-address view: INCR steps 8 bytes per beat, anything else stays put.
    function automatic logic [63:0] word_of(input logic [31:0] addr, input int beat,
                                            input logic [1:0] burst);
        logic [63:0] w;
        w = {32'd0, addr} >> 3;
        if (burst == 2'b01)
            w = w + 64'(beat);
        return w;
    endfunction

    function automatic logic [1:0] exp_err(input logic [31:0] addr, input int beat,
                                           input logic [1:0] burst, input logic [2:0] size,
                                           input bit wr);
        logic [63:0] w;
        w = word_of(addr, beat, burst);
        if (w >= 64'(NUM))                             return 2'b11;
        if (size > 3 || burst >= 2 || (wr && w == 0))  return 2'b10;
        return 2'b00;
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input int hold_b);
        int unsigned n;
        logic [1:0] e;
        logic [1:0] exp_b;
        logic [63:0] w;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        chk("wready_after_aw", wready, 1);
        exp_b = 2'b00;
        for (int b = 0; b < nbeats; b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
            chk("wready_beat", wready, 1);
            e = exp_err(addr, b, burst, size, 1'b1);
            if (e > exp_b) exp_b = e;
            if (e == 2'b00) begin
                w = word_of(addr, b, burst);
                for (int k = 0; k < 8; k++)
                    if (ws[b][k]) mregs[w[3:0]][8*k +: 8] = wd[b][8*k +: 8];
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid", bvalid, 1);
        chk("bid", bid, id);
        chk("bresp", bresp, exp_b);
        for (int h = 0; h < hold_b; h++) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1);
            chk("bid_hold", bid, id);
            chk("bresp_hold", bresp, exp_b);
            chk("awready_hold", awready, 0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall);
        int unsigned n;
        int unsigned tries;
        logic [1:0] e;
        logic [63:0] w;
        logic [63:0] ed;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            e = exp_err(addr, b, burst, size, 1'b0);
            w = word_of(addr, b, burst);
            ed = 64'd0;
            if (e == 2'b00) ed = (w == 0) ? VER : mregs[w[3:0]];
            tries = 0;
            do begin
                rready = (!stall || tries >= 4 || $urandom_range(0, 2) != 0);
                chk("rvalid", rvalid, 1);
                chk("rid", rid, id);
                chk("rdata", rdata, ed);
                chk("rresp", rresp, e);
                chk("rlast", rlast, (b == int'(len)));
                @(negedge clk);
                tries++;
            end while (!rready);
            rready = 1'b0;
        end
        chk("rvalid_end", rvalid, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        logic [1:0]  bu;
        logic [2:0]  sz;
        int          nb;

        for (int i = 0; i < int'(NUM); i++) mregs[i] = 64'd0;

        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bid_bresp", {bid, bresp}, 0);
        chk("rst_rid_rresp_rlast", {rid, rresp, rlast}, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_after_rst", awready, 1);
        chk("arready_after_rst", arready, 1);

        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write(4'd3, 32'h10, 8'd0, 3'd3, 2'b01, 1, 0);
        do_read(4'd9, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0);

        wd[0] = 64'hAAAAAAAABBBBBBBB; ws[0] = 8'h0F;
        do_write(4'd1, 32'h10, 8'd0, 3'd3, 2'b01, 1, 0);
        chk("strb_partial_model", mregs[2], 64'h11223344BBBBBBBB);
        do_read(4'd2, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0);

        for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
        do_write(4'd5, 32'h08, 8'd3, 3'd3, 2'b01, 4, 0);
        do_read(4'd9, 32'h08, 8'd3, 3'd3, 2'b01, 1'b0);

        wd[0] = 64'hCAFE_F00D_1234_5678; ws[0] = 8'hFF;
        do_write(4'd7, 32'h18, 8'd1, 3'd3, 2'b00, 1, 0);
        chk("awready_idle_after_early_wlast", awready, 1);
        do_read(4'd7, 32'h18, 8'd0, 3'd3, 2'b00, 1'b0);

        wd[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws[0] = 8'hFF;
        do_write(4'd2, 32'h80, 8'd0, 3'd3, 2'b01, 1, 0);
        do_write(4'd4, 32'h00, 8'd0, 3'd3, 2'b01, 1, 0);
        do_read(4'd6, 32'h00, 8'd0, 3'd3, 2'b01, 1'b0);
        do_read(4'd8, 32'h20, 8'd1, 3'd3, 2'b10, 1'b0);
        do_read(4'd1, 32'h70, 8'd3, 3'd3, 2'b01, 1'b0);

        wd[0] = 64'h0102_0304_0506_0708; ws[0] = 8'hFF;
        do_write(4'hA, 32'h28, 8'd0, 3'd3, 2'b01, 1, 5);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'h80 + 32'($urandom_range(0, 15)) * 8;
                1:       a = 32'h8000_0000 | 32'($urandom_range(0, 127)) * 8;
                default: a = 32'($urandom_range(0, NUM - 1)) * 8 + 32'($urandom_range(0, 7));
            endcase
            l  = 8'($urandom_range(0, 5));
            bu = ($urandom_range(0, 9) == 0) ? 2'b10 : (($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01);
            sz = ($urandom_range(0, 11) == 0) ? 3'd4 : 3'd3;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(l) + 1)) : int'(l) + 1;
            for (int b = 0; b < nb; b++) begin
                wd[b] = {$urandom, $urandom};
                ws[b] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            end
            do_write(4'($urandom), a, l, sz, bu, nb, int'($urandom_range(0, 2)));
            a  = 32'($urandom_range(0, NUM + 1)) * 8;
            l  = 8'($urandom_range(0, 4));
            bu = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'b01;
            do_read(4'($urandom), a, l, 3'd3, bu, 1'b1);
        end

        arid = 4'd3; araddr = 32'h08; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("mid_burst_rvalid", rvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_rvalid", rvalid, 0);
        chk("rst_async_arready", arready, 0);
        chk("rst_async_rdata", rdata, 0);
        for (int i = 0; i < int'(NUM); i++) mregs[i] = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arready_after_midburst_rst", arready, 1);
        chk("rvalid_after_midburst_rst", rvalid, 0);
        do_read(4'd0, 32'h00, 8'(NUM - 1), 3'd3, 2'b01, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
